bias_read_control: RTL and testbench

Reader side of the bias buffer. Bias_FIFO_CONTROL fills BiasBuffer from DDR; this block reads it back.
- On a conf pulse it streams bias_num beats starting at a configured buffer address.
- Each beat packs X_PE biases, assembled from WORDS_PER_BEAT consecutive DATA_LEN-bit buffer words.
- Beats are presented to the PE array over a valid/ready handshake with backpressure.

---
 rtl/bias_pkg.sv | 31 +++
 rtl/sync_word_fifo.sv | 65 ++++++
 rtl/bias_read_control.sv | 167 ++++++++++++++++
 tb/tb_bias_read_control.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared definitions for the bias buffer reader.
//   - Fixed geometry of the bias path (PE count, bias width, buffer word and
//     address widths, word FIFO depth).
//   - WORDS_PER_BEAT: buffer words needed to build one X_PE-wide beat.
//   - state_e: reader FSM states.
//   - word_count(): number of buffer words a run of bias_num beats reads.
package bias_pkg;

    localparam int X_PE           = 16;
    localparam int BIAS_LEN       = 8;
    localparam int ADDR_LEN       = 9;
    localparam int DATA_LEN       = 64;
    localparam int FIFO_DEPTH     = 4;
    localparam int BEAT_LEN       = X_PE * BIAS_LEN;
    localparam int WORDS_PER_BEAT = BEAT_LEN / DATA_LEN;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;

    // One extra bit so that bias_num * WORDS_PER_BEAT never overflows.
    function automatic logic [ADDR_LEN:0] word_count(input logic [ADDR_LEN-1:0] num);
        logic [ADDR_LEN:0] num_ext;
        num_ext = {1'b0, num};
        return num_ext * (ADDR_LEN+1)'(WORDS_PER_BEAT);
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Small synchronous word FIFO with first-word fall-through.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push        write push_data this cycle (caller guarantees not full)
//   push_data   word to write
//   pop         consume pop_data this cycle (caller guarantees not empty)
//   pop_data    oldest stored word, valid whenever count != 0
//   count       number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // NOTE: every signal gets a default before the ifs so no path leaves it unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments for all flops so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; clearing the pointers and count is enough to empty the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/bias_read_control.sv
// Reader side of the bias buffer. On an accepted conf pulse it reads
// bias_num * WORDS_PER_BEAT consecutive buffer words starting at bb_st_addr
// (wrapping at the top of the address space), packs each group of
// WORDS_PER_BEAT words into an X_PE-bias beat and hands the beats to the PE
// array over a valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   conf                start pulse, sampled only in IDLE
//   bias_num            beats to deliver, latched on accepted conf
//   bb_st_addr          first buffer word address, latched on accepted conf
//   bb_rd_en/_addr      buffer read request
//   bb_rd_data          buffer read data, one cycle after bb_rd_en
//   bias_out/_valid     assembled beat; first word read sits in the low bits
//   bias_ready          consumer accepts on bias_valid && bias_ready
//   busy                high in READ and DRAIN
//   done                one-cycle completion pulse
module bias_read_control
    import bias_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                conf,
    input  logic [ADDR_LEN-1:0] bias_num,
    input  logic [ADDR_LEN-1:0] bb_st_addr,
    output logic                bb_rd_en,
    output logic [ADDR_LEN-1:0] bb_rd_addr,
    input  logic [DATA_LEN-1:0] bb_rd_data,
    output logic [BEAT_LEN-1:0] bias_out,
    output logic                bias_valid,
    input  logic                bias_ready,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int IDX_W = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [ADDR_LEN:0]   words_left_q, words_left_d;
    logic [ADDR_LEN:0]   beats_left_q, beats_left_d;
    logic                inflight_q;

    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_LEN-1:0] fifo_data;
    logic                fifo_pop;

    logic [BEAT_LEN-1:0] beat_q, beat_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic                valid_q, valid_d;

    logic                rd_issue;
    logic                handshake;

    // Credit check: words already stored plus the one still returning must
    // leave room for the word requested now, so the FIFO can never overflow.
    assign rd_issue  = (state_q == READ) &&
                       ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
    assign handshake = valid_q && bias_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state and run counters ----------------
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        beats_left_d = beats_left_q;

        if (handshake) beats_left_d = beats_left_q - (ADDR_LEN+1)'(1);

        case (state_q)
            IDLE: begin
                if (conf) begin
                    addr_d       = bb_st_addr;
                    words_left_d = word_count(bias_num);
                    beats_left_d = {1'b0, bias_num};
                    state_d      = (bias_num == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (rd_issue) begin
                    addr_d       = addr_q + ADDR_LEN'(1);
                    words_left_d = words_left_q - (ADDR_LEN+1)'(1);
                    if (words_left_q == (ADDR_LEN+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && beats_left_q == (ADDR_LEN+1)'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bb_rd_en   = rd_issue;
        bb_rd_addr = rd_issue ? addr_q : '0;
        busy       = (state_q == READ) || (state_q == DRAIN);
        done       = (state_q == DONE);
    end

    // ---------------- Word FIFO ----------------
    // inflight_q marks the cycle in which bb_rd_data carries a requested word.
    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_LEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bb_rd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count)
    );

    // ---------------- Beat assembler ----------------
    // A word may be loaded only when the beat register is free or its beat is
    // being accepted this cycle; that keeps bias_out stable while stalled.
    assign fifo_pop = (fifo_count != '0) && (!valid_q || bias_ready);

    always_comb begin
        beat_d     = beat_q;
        word_idx_d = word_idx_q;
        valid_d    = valid_q;
        if (handshake) valid_d = 1'b0;
        if (fifo_pop) begin
            beat_d[word_idx_q*DATA_LEN +: DATA_LEN] = fifo_data;
            if (word_idx_q == IDX_W'(WORDS_PER_BEAT - 1)) begin
                word_idx_d = '0;
                valid_d    = 1'b1;
            end else begin
                word_idx_d = word_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            words_left_q <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
            beat_q       <= '0;
            word_idx_q   <= '0;
            valid_q      <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= rd_issue;
            beat_q       <= beat_d;
            word_idx_q   <= word_idx_d;
            valid_q      <= valid_d;
        end
    end

    assign bias_out   = beat_q;
    assign bias_valid = valid_q;

endmodule

// File: tb/tb_bias_read_control.sv
// Self-checking bench for bias_read_control. A bias buffer model returns
// {32'hB1A5, address} one cycle after each read. Every started run pushes the
// expected read addresses and beats into queues; an independent monitor at
// the falling edge pops and compares whenever the DUT issues a read or
// completes a beat handshake, and checks done timing, stalls and latency.
module tb_bias_read_control;

    localparam int AW   = 9;
    localparam int DW   = 64;
    localparam int BW   = 128;
    localparam int ASPC = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          conf;
    logic [AW-1:0] bias_num;
    logic [AW-1:0] bb_st_addr;
    logic          bb_rd_en;
    logic [AW-1:0] bb_rd_addr;
    logic [DW-1:0] bb_rd_data = '0;
    logic [BW-1:0] bias_out;
    logic          bias_valid;
    logic          bias_ready;
    logic          busy;
    logic          done;

    bias_read_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conf       (conf),
        .bias_num   (bias_num),
        .bb_st_addr (bb_st_addr),
        .bb_rd_en   (bb_rd_en),
        .bb_rd_addr (bb_rd_addr),
        .bb_rd_data (bb_rd_data),
        .bias_out   (bias_out),
        .bias_valid (bias_valid),
        .bias_ready (bias_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] word_of(input int a);
        return {32'hB1A5, a[31:0]};
    endfunction

    // Bias buffer model: one cycle read latency.
    always @(posedge clk) begin
        if (bb_rd_en) bb_rd_data <= word_of(int'(bb_rd_addr));
    end

    // Cycle counter and consumer: 0 = always ready, 1 = pattern 1,0,0, 2 = random.
    int cyc        = 0;
    int ready_mode = 0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        case (ready_mode)
            0:       bias_ready = 1'b1;
            1:       bias_ready = (cyc % 3 == 0);
            default: bias_ready = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Scoreboard state shared between stimulus and monitor.
    int            exp_addr_q[$];
    logic [BW-1:0] exp_beat_q[$];
    int            expect_done_cycle = -1;
    int            conf_cyc          = 0;
    bit            first_pending     = 0;
    int            issued            = 0;
    int            accepted          = 0;
    int            last_rd_cyc       = 0;
    int            done_cnt          = 0;
    bit            prev_hold         = 0;
    logic [BW-1:0] prev_out          = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 0;
        end else begin
            // Read requests.
            if (bb_rd_en) begin
                issued++;
                if (exp_addr_q.size() == 0) begin
                    check("rd_unexpected", bb_rd_en, 1'b0);
                end else begin
                    check("rd_addr", bb_rd_addr, exp_addr_q.pop_front());
                end
                // Words held between buffer and consumer: FIFO + inflight <= 4, beat register <= 2.
                check("rd_credit", (issued - 2 * accepted) <= 6, 1'b1);
                if (ready_mode == 0 && issued > 1) check("rd_back_to_back", cyc - last_rd_cyc, 1);
                last_rd_cyc = cyc;
            end
            // Stall stability.
            if (prev_hold) begin
                check("hold_valid", bias_valid, 1'b1);
                check("hold_data", bias_out, prev_out);
            end
            // First beat latency from the conf edge.
            if (first_pending && bias_valid) begin
                check("first_valid_latency", (cyc - conf_cyc) <= 5, 1'b1);
                first_pending = 0;
            end
            // Beat handshakes.
            if (bias_valid && bias_ready) begin
                accepted++;
                if (exp_beat_q.size() == 0) begin
                    check("beat_unexpected", bias_valid, 1'b0);
                end else begin
                    check("beat_data", bias_out, exp_beat_q.pop_front());
                    if (exp_beat_q.size() == 0) expect_done_cycle = cyc + 1;
                end
            end
            // Done pulse: exactly when expected, never otherwise.
            if (done || expect_done_cycle == cyc) begin
                check("done_timing", done, expect_done_cycle == cyc);
                if (done) begin
                    check("busy_with_done", busy, 1'b0);
                    done_cnt++;
                end
                expect_done_cycle = -1;
            end
            prev_hold = bias_valid && !bias_ready;
            prev_out  = bias_out;
        end
    end

    task automatic start_run(input int st, input int n);
        @(posedge clk);
        #1;
        bb_st_addr = AW'(st);
        bias_num   = AW'(n);
        conf       = 1'b1;
        issued     = 0;
        accepted   = 0;
        conf_cyc   = cyc;
        for (int i = 0; i < 2 * n; i++) exp_addr_q.push_back((st + i) % ASPC);
        for (int b = 0; b < n; b++)
            exp_beat_q.push_back({word_of((st + 2 * b + 1) % ASPC), word_of((st + 2 * b) % ASPC)});
        if (n == 0) expect_done_cycle = cyc + 1;
        else        first_pending = 1;
        @(posedge clk);
        #1;
        conf = 1'b0;
        check("busy_after_conf", busy, n != 0);
    endtask

    task automatic wait_done();
        int start_cnt;
        bit seen;
        start_cnt = done_cnt;
        seen      = 0;
        for (int i = 0; i < 400; i++) begin
            if (done_cnt > start_cnt) begin
                seen = 1;
                break;
            end
            @(posedge clk);
        end
        check("run_completed", seen, 1'b1);
        check("beats_outstanding", exp_beat_q.size(), 0);
        check("reads_outstanding", exp_addr_q.size(), 0);
        exp_beat_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, bb_rd_en, 1'b0);
        check({tag, "_rd_addr"}, bb_rd_addr, '0);
        check({tag, "_bias_out"}, bias_out, '0);
        check({tag, "_bias_valid"}, bias_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        bit reached;
        rst_n      = 1'b0;
        conf       = 1'b0;
        bias_num   = '0;
        bb_st_addr = '0;
        bias_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: basic run, consumer always ready.
        ready_mode = 0;
        start_run(0, 3);
        wait_done();

        // 2: consumer stalls with pattern 1,0,0.
        ready_mode = 1;
        start_run(0, 3);
        wait_done();
        start_run(7, 8);
        wait_done();

        // 3: address wrap.
        ready_mode = 0;
        start_run(510, 2);
        wait_done();

        // 4: empty run.
        start_run(33, 0);
        wait_done();

        // 5: conf while busy is ignored.
        start_run(20, 4);
        @(posedge clk);
        #1;
        bb_st_addr = AW'(100);
        bias_num   = AW'(7);
        conf       = 1'b1;
        @(posedge clk);
        #1;
        conf = 1'b0;
        wait_done();

        // 6: reset after the second read of a 4-beat run.
        start_run(300, 4);
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            if (issued >= 2) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        check("reset_point_reached", reached, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_addr_q.delete();
        exp_beat_q.delete();
        expect_done_cycle = -1;
        first_pending     = 0;
        #1;
        check_outputs_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        start_run(40, 3);
        wait_done();

        // Random runs against the model, random backpressure.
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            start_run(int'($urandom_range(0, ASPC - 1)), int'($urandom_range(1, 8)));
            wait_done();
        end
        start_run(505, 6);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
